// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame parser: FSM states, error codes,
// default sync marker and a small index-width helper.
package uart_pkg;

  typedef enum logic [2:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CSUM,
    DRAIN
  } state_t;

  localparam logic [1:0] ERR_OVERRUN = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Index width for a buffer of the given depth; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: MAX_LEN x 8 register array, synchronous write,
// combinational read.
module uart_frame_buf
  import uart_pkg::*;
#(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned AW      = idx_width(MAX_LEN)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_idx,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [MAX_LEN];

  // Store one payload byte per accepted write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/uart_frame_parser.sv
// Frame parser behind a UART receiver: hunts for SYNC_BYTE, reads a length,
// buffers the payload, verifies an XOR checksum and only then streams the
// payload out on a valid/ready interface. Bad frames raise frame_err.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE   = DEFAULT_SYNC_BYTE,
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 4800
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int unsigned    AW        = idx_width(MAX_LEN);
  localparam int unsigned    TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);

  state_t        state, state_n;
  logic          in_valid_d;
  logic [7:0]    len, len_n;
  logic [7:0]    csum_acc, csum_n;
  logic [AW-1:0] idx, idx_n;
  logic [AW-1:0] rd_idx, rd_idx_n;
  logic [TW-1:0] tmo_cnt, tmo_n;
  logic          ok_n, err_n;
  logic [1:0]    code_n;
  logic          wr_en;
  logic [7:0]    buf_rd_data;
  logic [7:0]    len_last;
  logic          accept;
  logic          tmo_expired;
  logic          xfer;

  assign accept      = in_valid && !in_valid_d;
  assign len_last    = len - 8'd1;
  assign tmo_expired = (tmo_cnt == TMO_LAST);

  assign out_valid = (state == DRAIN);
  assign out_last  = out_valid && (8'(rd_idx) == len_last);
  assign out_data  = out_valid ? buf_rd_data : '0;
  assign busy      = (state != HUNT);
  assign xfer      = out_valid && out_ready;

  uart_frame_buf #(
    .MAX_LEN (MAX_LEN),
    .AW      (AW)
  ) u_frame_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (idx),
    .wr_data (in_data),
    .rd_idx  (rd_idx),
    .rd_data (buf_rd_data)
  );

  // State and datapath registers; error/ok strobes are registered one-cycle pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= HUNT;
      in_valid_d <= 1'b1;
      len        <= '0;
      csum_acc   <= '0;
      idx        <= '0;
      rd_idx     <= '0;
      tmo_cnt    <= '0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= ERR_OVERRUN;
    end else begin
      state      <= state_n;
      in_valid_d <= in_valid;
      len        <= len_n;
      csum_acc   <= csum_n;
      idx        <= idx_n;
      rd_idx     <= rd_idx_n;
      tmo_cnt    <= tmo_n;
      frame_ok   <= ok_n;
      frame_err  <= err_n;
      err_code   <= err_n ? code_n : ERR_OVERRUN;
    end
  end

  // Next-state, timeout and error decisions; an accept always beats a timeout.
  always_comb begin
    state_n  = state;
    len_n    = len;
    csum_n   = csum_acc;
    idx_n    = idx;
    rd_idx_n = rd_idx;
    tmo_n    = '0;
    ok_n     = 1'b0;
    err_n    = 1'b0;
    code_n   = ERR_OVERRUN;
    wr_en    = 1'b0;

    case (state)
      HUNT: begin
        if (accept && (in_data == SYNC_BYTE)) begin
          state_n = LEN;
        end
      end

      LEN: begin
        tmo_n = tmo_cnt + TW'(1);
        if (accept) begin
          tmo_n = '0;
          if ((in_data == 8'd0) || (in_data > MAX_LEN_B)) begin
            err_n   = 1'b1;
            code_n  = ERR_LEN;
            state_n = HUNT;
          end else begin
            len_n   = in_data;
            csum_n  = in_data;
            idx_n   = '0;
            state_n = PAYLOAD;
          end
        end else if (tmo_expired) begin
          err_n   = 1'b1;
          code_n  = ERR_TIMEOUT;
          state_n = HUNT;
        end
      end

      PAYLOAD: begin
        tmo_n = tmo_cnt + TW'(1);
        if (accept) begin
          tmo_n  = '0;
          wr_en  = 1'b1;
          csum_n = csum_acc ^ in_data;
          idx_n  = idx + AW'(1);
          if (8'(idx) == len_last) begin
            state_n = CSUM;
          end
        end else if (tmo_expired) begin
          err_n   = 1'b1;
          code_n  = ERR_TIMEOUT;
          state_n = HUNT;
        end
      end

      CSUM: begin
        tmo_n = tmo_cnt + TW'(1);
        if (accept) begin
          tmo_n = '0;
          if (in_data == csum_acc) begin
            rd_idx_n = '0;
            ok_n     = 1'b1;
            state_n  = DRAIN;
          end else begin
            err_n   = 1'b1;
            code_n  = ERR_CSUM;
            state_n = HUNT;
          end
        end else if (tmo_expired) begin
          err_n   = 1'b1;
          code_n  = ERR_TIMEOUT;
          state_n = HUNT;
        end
      end

      DRAIN: begin
        if (accept) begin
          err_n  = 1'b1;
          code_n = ERR_OVERRUN;
        end
        if (xfer) begin
          rd_idx_n = rd_idx + AW'(1);
          if (out_last) begin
            state_n = HUNT;
          end
        end
      end

      default: begin
        state_n = HUNT;
      end
    endcase
  end

endmodule
